result_transpose_stage: RTL

Downstream stage of the matrix-multiply engine in the self-attention datapath. It reads a finished result matrix (for example K) from the result SRAM and writes its transpose into a scratch SRAM, so the next multiply pass can compute Q·Kᵀ with the existing row-major read pattern. It uses the same header format as the multiply engine: a dimension word at the base address, then elements in row-major order. It also uses the same dut_valid/dut_ready handshake.

---
 rtl/result_transpose_stage_pkg.sv | 22 ++
 rtl/transpose_addr_gen.sv | 109 ++++++++++
 rtl/result_transpose_stage.sv | 123 ++++++++++++
 3 files changed

// File: rtl/result_transpose_stage_pkg.sv
// Shared definitions for the result transpose stage: FSM states, header field
// positions and default bus widths.
package result_transpose_stage_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned CNT_W      = 16;

    localparam int unsigned ROWS_MSB = 31;
    localparam int unsigned ROWS_LSB = 16;
    localparam int unsigned COLS_MSB = 15;
    localparam int unsigned COLS_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        HDR_RD,
        HDR_CAP,
        HDR_WR,
        STREAM
    } state_e;

endpackage

// File: rtl/transpose_addr_gen.sv
// Column-order address generator: walks the source matrix column by column
// using only adders, and steps the destination address once per write.
module transpose_addr_gen
    import result_transpose_stage_pkg::*;
#(
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] SRC_BASE = '0,
    parameter logic [ADDR_W-1:0] DST_BASE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              load_hdr,
    input  logic              advance,
    input  logic              wr_step,
    input  logic [CNT_W-1:0]  rows_in,
    input  logic [CNT_W-1:0]  cols_in,
    output logic [CNT_W-1:0]  rows,
    output logic [CNT_W-1:0]  cols,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              last_element
);

    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  C_ONE = CNT_W'(1);

    logic [CNT_W-1:0]  rows_q, rows_d, cols_q, cols_d;
    logic [CNT_W-1:0]  row_q, row_d, col_q, col_d;
    logic [ADDR_W-1:0] col_start_q, col_start_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              last_q, last_d;
    logic              row_last, col_last;

    assign row_last = ((row_q + C_ONE) == rows_q);
    assign col_last = ((col_q + C_ONE) == cols_q);

    always_comb begin
        rows_d      = rows_q;
        cols_d      = cols_q;
        row_d       = row_q;
        col_d       = col_q;
        col_start_d = col_start_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        last_d      = last_q;

        if (wr_step) begin
            wr_addr_d = wr_addr_q + A_ONE;
        end

        if (start) begin
            rd_addr_d = SRC_BASE;
            last_d    = 1'b0;
        end else if (load_hdr) begin
            rows_d      = rows_in;
            cols_d      = cols_in;
            row_d       = '0;
            col_d       = '0;
            col_start_d = SRC_BASE + A_ONE;
            rd_addr_d   = SRC_BASE + A_ONE;
            wr_addr_d   = DST_BASE;
            last_d      = 1'b0;
        end else if (advance) begin
            // last_q marks that the element now being written is the final one
            if (row_last && col_last) begin
                last_d = 1'b1;
            end else if (row_last) begin
                row_d       = '0;
                col_d       = col_q + C_ONE;
                col_start_d = col_start_q + A_ONE;
                rd_addr_d   = col_start_q + A_ONE;
            end else begin
                row_d     = row_q + C_ONE;
                rd_addr_d = rd_addr_q + ADDR_W'(cols_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rows_q      <= '0;
            cols_q      <= '0;
            row_q       <= '0;
            col_q       <= '0;
            col_start_q <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            last_q      <= 1'b0;
        end else begin
            rows_q      <= rows_d;
            cols_q      <= cols_d;
            row_q       <= row_d;
            col_q       <= col_d;
            col_start_q <= col_start_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            last_q      <= last_d;
        end
    end

    assign rows         = rows_q;
    assign cols         = cols_q;
    assign rd_addr      = rd_addr_q;
    assign wr_addr      = wr_addr_q;
    assign last_element = last_q;

endmodule

// File: rtl/result_transpose_stage.sv
// Copies a row-major result matrix from the result SRAM into the scratch SRAM
// as its transpose, rewriting the {rows,cols} header accordingly.
module result_transpose_stage
    import result_transpose_stage_pkg::*;
#(
    parameter int unsigned       DATA_W   = DATA_W_DEF,
    parameter int unsigned       ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] SRC_BASE = '0,
    parameter logic [ADDR_W-1:0] DST_BASE = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dut_valid,
    output logic              dut_ready,
    output logic [ADDR_W-1:0] dut__tb__sram_result_read_address,
    input  logic [DATA_W-1:0] tb__dut__sram_result_read_data,
    output logic              dut__tb__sram_scratch_write_enable,
    output logic [ADDR_W-1:0] dut__tb__sram_scratch_write_address,
    output logic [DATA_W-1:0] dut__tb__sram_scratch_write_data
);

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              we_q, we_d;
    logic              start, load_hdr, advance;
    logic              last_element;
    logic [CNT_W-1:0]  rows, cols;
    logic [ADDR_W-1:0] rd_addr, wr_addr;

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        load_hdr = 1'b0;
        advance  = 1'b0;

        case (state_q)
            IDLE: begin
                if (dut_valid) begin
                    start   = 1'b1;
                    state_d = HDR_RD;
                end
            end
            HDR_RD: begin
                state_d = HDR_CAP;
            end
            HDR_CAP: begin
                load_hdr = 1'b1;
                state_d  = HDR_WR;
            end
            HDR_WR: begin
                if (rows == '0 || cols == '0) begin
                    state_d = IDLE;
                end else begin
                    advance = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (last_element) begin
                    state_d = IDLE;
                end else begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobe and ready are registered so they line up with the address registers
        we_d    = (state_d == HDR_WR) || (state_d == STREAM);
        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            we_q    <= we_d;
        end
    end

    transpose_addr_gen #(
        .ADDR_W   (ADDR_W),
        .SRC_BASE (SRC_BASE),
        .DST_BASE (DST_BASE)
    ) u_addr_gen (
        .clk          (clk),
        .rst          (reset),
        .start        (start),
        .load_hdr     (load_hdr),
        .advance      (advance),
        .wr_step      (we_q),
        .rows_in      (tb__dut__sram_result_read_data[ROWS_MSB:ROWS_LSB]),
        .cols_in      (tb__dut__sram_result_read_data[COLS_MSB:COLS_LSB]),
        .rows         (rows),
        .cols         (cols),
        .rd_addr      (rd_addr),
        .wr_addr      (wr_addr),
        .last_element (last_element)
    );

    always_comb begin
        dut__tb__sram_scratch_write_data = '0;
        if (we_q) begin
            if (state_q == HDR_WR) begin
                dut__tb__sram_scratch_write_data = DATA_W'({cols, rows});
            end else begin
                dut__tb__sram_scratch_write_data = tb__dut__sram_result_read_data;
            end
        end
    end

    assign dut_ready                           = ready_q;
    assign dut__tb__sram_result_read_address   = rd_addr;
    assign dut__tb__sram_scratch_write_enable  = we_q;
    assign dut__tb__sram_scratch_write_address = wr_addr;

endmodule
